// File: rtl/vdec_hs_pkg.sv
// Shared constants and types for the HS control-channel K=9, rate-1/3 convolutional encoder.
package vdec_hs_pkg;

    localparam int HS_MAX_BLK  = 29;
    localparam int HS_TAIL_LEN = 8;
    localparam int HS_K        = 9;

    localparam logic [8:0] HS_G0 = 9'o557;
    localparam logic [8:0] HS_G1 = 9'o663;
    localparam logic [8:0] HS_G2 = 9'o711;

    // Generators packed so generate loops can slice HS_GENS[k*HS_K +: HS_K]
    localparam logic [3*HS_K-1:0] HS_GENS = {HS_G2, HS_G1, HS_G0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2,
        FIN  = 2'd3
    } hs_state_t;

endpackage

// File: rtl/vdec_hs_cenc_if.sv
// Coded-symbol stream between the encoder and rate matching: valid/ready with a 3-bit symbol.
interface vdec_hs_cenc_if;
    logic       sym_valid;
    logic       sym_ready;
    logic [2:0] sym_data;

    modport master (output sym_valid, output sym_data, input sym_ready);
    modport slave  (input sym_valid, input sym_data, output sym_ready);
endinterface

// File: rtl/vdec_hs_cenc_sreg.sv
// Encoder shift register sr[7:0] (sr[0]=u[t-1]) plus generator taps for the symbol that follows the update.
module vdec_hs_cenc_sreg
    import vdec_hs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       u,
    input  logic       u_nxt,
    output logic [2:0] c_nxt
);

    logic [7:0] sr_reg;
    logic [7:0] sr_next;
    logic [8:0] tap_vec;

    always_comb begin
        sr_next = sr_reg;
        if (clr) begin
            sr_next = '0;
        end else if (en) begin
            sr_next = {sr_reg[6:0], u};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= sr_next;
        end
    end

    // Align taps with generator bits: bit 8 is the new input, bit 8-j is u[t-j]
    assign tap_vec[8] = u_nxt;
    for (genvar gi = 0; gi < 8; gi++) begin : g_tap
        assign tap_vec[gi] = sr_next[7-gi];
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_code
        assign c_nxt[gi] = ^(tap_vec & HS_GENS[gi*HS_K +: HS_K]);
    end

endmodule

// File: rtl/vdec_hs_cenc.sv
// HS control-channel convolutional encoder top: FSM, symbol counter and registered symbol stream.
// Optional status ports start_err/sym_idx are built when HS_CENC_STATUS_EN is defined.
module vdec_hs_cenc
    import vdec_hs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [28:0] info_bits,
    input  logic [4:0]  codeblk_size,
    output logic        busy,
    output logic        done,
    output logic [5:0]  codeblk_size_p7,
    vdec_hs_cenc_if.master sym
`ifdef HS_CENC_STATUS_EN
    ,
    output logic        start_err,
    output logic [5:0]  sym_idx
`endif
);

    hs_state_t   state_reg;
    logic [28:0] info_reg;
    logic [4:0]  size_reg;
    logic [5:0]  cnt_reg;
    logic [5:0]  p7_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        sym_valid_reg;
    logic [2:0]  sym_data_reg;

    logic        start_acc;
    logic        hs;
    logic [4:0]  size_clamp;
    logic [28:0] info_mask;
    logic        u_nxt;
    logic [2:0]  c_nxt;

    assign start_acc  = start && (state_reg == IDLE);
    assign hs         = sym_valid_reg && sym.sym_ready;
    assign size_clamp = (codeblk_size > 5'(HS_MAX_BLK)) ? 5'(HS_MAX_BLK) : codeblk_size;
    // Bits above the block size are zeroed so shifting info_reg naturally feeds the zero tail
    assign info_mask  = info_bits & ~({29{1'b1}} << size_clamp);
    assign u_nxt      = start_acc ? info_mask[0] : info_reg[1];

    vdec_hs_cenc_sreg u_sreg (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (hs),
        .u     (info_reg[0]),
        .u_nxt (u_nxt),
        .c_nxt (c_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            info_reg      <= '0;
            size_reg      <= '0;
            cnt_reg       <= '0;
            p7_reg        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sym_valid_reg <= 1'b0;
            sym_data_reg  <= '0;
`ifdef HS_CENC_STATUS_EN
            start_err     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef HS_CENC_STATUS_EN
            start_err <= start && (state_reg != IDLE);
`endif
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        info_reg      <= info_mask;
                        size_reg      <= size_clamp;
                        p7_reg        <= 6'(size_clamp) + 6'd7;
                        cnt_reg       <= '0;
                        busy_reg      <= 1'b1;
                        sym_valid_reg <= 1'b1;
                        sym_data_reg  <= c_nxt;
                        state_reg     <= (size_clamp != '0) ? DATA : TAIL;
                    end
                end
                DATA: begin
                    if (hs) begin
                        info_reg     <= info_reg >> 1;
                        cnt_reg      <= cnt_reg + 6'd1;
                        sym_data_reg <= c_nxt;
                        if (cnt_reg == 6'(size_reg) - 6'd1) begin
                            state_reg <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (hs) begin
                        info_reg     <= info_reg >> 1;
                        cnt_reg      <= cnt_reg + 6'd1;
                        sym_data_reg <= c_nxt;
                        if (cnt_reg == 6'(size_reg) + 6'(HS_TAIL_LEN - 1)) begin
                            sym_valid_reg <= 1'b0;
                            state_reg     <= FIN;
                        end
                    end
                end
                FIN: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy            = busy_reg;
    assign done            = done_reg;
    assign codeblk_size_p7 = p7_reg;
    assign sym.sym_valid   = sym_valid_reg;
    assign sym.sym_data    = sym_data_reg;
`ifdef HS_CENC_STATUS_EN
    assign sym_idx         = cnt_reg;
`endif

endmodule

// File: tb/tb_vdec_hs_cenc.sv
// Self-checking bench for vdec_hs_cenc: golden-model scoreboard of coded symbols plus timing/boundary checks.
module tb_vdec_hs_cenc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [28:0] info_bits = '0;
    logic [4:0]  codeblk_size = '0;
    logic        busy;
    logic        done;
    logic [5:0]  codeblk_size_p7;
`ifdef HS_CENC_STATUS_EN
    logic        start_err;
    logic [5:0]  sym_idx;
`endif

    vdec_hs_cenc_if sif ();

    vdec_hs_cenc dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .info_bits       (info_bits),
        .codeblk_size    (codeblk_size),
        .busy            (busy),
        .done            (done),
        .codeblk_size_p7 (codeblk_size_p7),
        .sym             (sif)
`ifdef HS_CENC_STATUS_EN
        ,
        .start_err       (start_err),
        .sym_idx         (sym_idx)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    int         acc_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Direct convolution: c_k(t) = XOR_i g_k[8-i] & u[t-i], u beyond the block is zero
    function automatic logic [2:0] gold(input logic [28:0] bits, input int n, input int t);
        logic [2:0] c;
        logic [8:0] g;
        logic       u;
        int         idx;
        c = '0;
        for (int k = 0; k < 3; k++) begin
            g = (k == 0) ? 9'o557 : (k == 1) ? 9'o663 : 9'o711;
            for (int i = 0; i < 9; i++) begin
                idx = t - i;
                u = (idx >= 0 && idx < n) ? bits[idx] : 1'b0;
                c[k] = c[k] ^ (g[8-i] & u);
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rst && sif.sym_valid) begin
            if (exp_q.size() == 0) begin
                chk("sym_unexpected", 32'(sif.sym_valid), 32'd0);
            end else if (sif.sym_ready) begin
                chk($sformatf("sym%0d", acc_cnt), 32'(sif.sym_data), 32'(exp_q.pop_front()));
`ifdef HS_CENC_STATUS_EN
                chk("sym_idx", 32'(sym_idx), 32'(acc_cnt));
`endif
                acc_cnt++;
            end else begin
                chk("sym_hold", 32'(sif.sym_data), 32'(exp_q[0]));
            end
        end
    end

    task automatic push_block(input logic [28:0] bits, input int n);
        for (int t = 0; t < n + 8; t++) exp_q.push_back(gold(bits, n, t));
    endtask

    task automatic run_blk(input string name, input logic [28:0] bits, input logic [4:0] size,
                           input int exp_cyc, input int stall_at, input int stall_len,
                           input bit rnd, input int ign_at);
        int n;
        int cyc;
        int sl;
        n = (size > 5'd29) ? 29 : int'(size);
        push_block(bits, n);
        acc_cnt = 0;
        sl = stall_len;
        start = 1'b1;
        info_bits = bits;
        codeblk_size = size;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({name, "_valid_lat1"}, 32'(sif.sym_valid), 32'd1);
        while (!done && cyc < 400) begin
            if (cyc == ign_at) begin
                start = 1'b1;
                codeblk_size = 5'd3;
                info_bits = 29'($urandom);
            end else begin
                start = 1'b0;
            end
            if (rnd) sif.sym_ready = 1'($urandom_range(0, 1));
            else if (acc_cnt == stall_at && sl > 0) begin
                sif.sym_ready = 1'b0;
                sl--;
            end else sif.sym_ready = 1'b1;
            @(posedge clk); #1;
            cyc++;
`ifdef HS_CENC_STATUS_EN
            if (ign_at >= 0 && cyc == ign_at + 1) chk({name, "_start_err"}, 32'(start_err), 32'd1);
`endif
        end
        start = 1'b0;
        sif.sym_ready = 1'b1;
        chk({name, "_done_seen"}, 32'(done), 32'd1);
        if (exp_cyc >= 0) chk({name, "_done_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_p7"}, 32'(codeblk_size_p7), 32'(n + 7));
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        $display("block %s size=%0d symbols=%0d cycles=%0d", name, n, acc_cnt, cyc);
    endtask

    initial begin
        int  cyc;
        bit  seen_done;
        sif.sym_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid", 32'(sif.sym_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p7", 32'(codeblk_size_p7), 32'd0);
        chk("rst_data", 32'(sif.sym_data), 32'd0);

        // T1..T4, each start lands in the done cycle of the previous block
        run_blk("T1_zero29", 29'd0, 5'd29, 38, -1, 0, 1'b0, -1);
        run_blk("T2_impulse", 29'd1, 5'd1, 10, -1, 0, 1'b0, -1);
        run_blk("T3_stall", 29'd1, 5'd1, 13, 4, 3, 1'b0, -1);
        run_blk("T4_size0", 29'h1555_5555, 5'd0, 9, -1, 0, 1'b0, -1);
        run_blk("T4_size31", 29'h1FFF_FFFF, 5'd31, 38, -1, 0, 1'b0, -1);

        // T5: random payloads with full-rate and random ready
        for (int i = 0; i < 3; i++) begin
            run_blk("T5_rand", 29'($urandom), 5'd29, 38, -1, 0, 1'b0, -1);
            run_blk("T5_rand_rdy", 29'($urandom), 5'(1 + $urandom_range(0, 28)), -1, -1, 0, 1'b1, -1);
        end

        // T6: start while busy is ignored
        run_blk("T6_ignore", 29'($urandom), 5'd20, 29, -1, 0, 1'b0, 5);

        // T6: reset at symbol 10
        @(posedge clk); #1;
        push_block(29'h0ABC_DEF1, 29);
        acc_cnt = 0;
        start = 1'b1;
        info_bits = 29'h0ABC_DEF1;
        codeblk_size = 5'd29;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (acc_cnt < 10 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_mid_reached_sym10", 32'(acc_cnt), 32'd10);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(sif.sym_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_p7", 32'(codeblk_size_p7), 32'd0);
        chk("rst_mid_data", 32'(sif.sym_data), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        chk("rst_mid_no_done", 32'(seen_done), 32'd0);
        run_blk("T6_after_rst", 29'h1234_5678, 5'd17, 26, -1, 0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
